// File: rtl/i2c_wr_engine_if.sv
// Configuration-side bundle for the I2C write engine: 24-bit word, level request GO,
// completion flag END and sticky NACK flag ACK. master = sequencer, slave = engine.
interface i2c_wr_engine_if;
  logic [23:0] I2C_DATA;
  logic        GO;
  logic        END;
  logic        ACK;

  modport master (
    output I2C_DATA, GO,
    input  END, ACK
  );

  modport slave (
    input  I2C_DATA, GO,
    output END, ACK
  );
endinterface

// File: rtl/i2c_wr_engine.sv
// I2C master write engine: sends {slave_addr, sub_addr, data} as one 3-byte write
// (START, 3 x (8 bits + ACK), STOP) timed by an internal quarter-bit tick.
// Ports: CLOCK_50, reset (async, active-high), cfg (I2C_DATA/GO in, END/ACK out),
// FPGA_I2C_SCLK (push-pull SCL), FPGA_I2C_SDAT (open-drain SDA, drives 0 or Z).
// Optional: define I2C_ABORT_ON_NACK_EN to jump to STOP on the first NACK.
module i2c_wr_engine #(
  parameter int CLK_Freq = 50000000,
  parameter int I2C_Freq = 20000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  i2c_wr_engine_if.slave    cfg,
  output logic              FPGA_I2C_SCLK,
  inout  wire               FPGA_I2C_SDAT
);

  localparam int Q  = CLK_Freq / (4 * I2C_Freq);
  localparam int CW = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [CW-1:0] QMAX = CW'(Q - 1);

`ifdef I2C_ABORT_ON_NACK_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, START, BIT, ACKS, STOP, DONE
  } state_t;

  state_t      state, n_state;
  logic [1:0]  phase, n_phase;
  logic [CW-1:0] cnt;
  logic [23:0] shreg, n_shift;
  logic [1:0]  byte_idx, n_byte;
  logic [2:0]  bit_idx, n_bit;
  logic        end_r, n_end;
  logic        ack_r, n_ack;
  logic        scl, n_scl;
  logic        sda_oe, n_oe;
  logic        sda_m, sda_s;
  logic        qtick;

  assign qtick         = (cnt == QMAX);
  assign cfg.END       = end_r;
  assign cfg.ACK       = ack_r;
  assign FPGA_I2C_SCLK = scl;
  assign FPGA_I2C_SDAT = sda_oe ? 1'b0 : 1'bz;

  always_comb begin
    n_state = state;
    n_phase = phase;
    n_shift = shreg;
    n_byte  = byte_idx;
    n_bit   = bit_idx;
    n_end   = end_r;
    n_ack   = ack_r;
    case (state)
      IDLE: begin
        if (cfg.GO && !end_r) begin
          n_state = START;
          n_phase = 2'd0;
          n_shift = cfg.I2C_DATA;
          n_ack   = 1'b0;
        end
      end
      DONE: begin
        n_end = 1'b1;
        // Leaving DONE needs GO observed low, which blocks retrigger.
        if (!cfg.GO) begin
          n_end   = 1'b0;
          n_state = IDLE;
        end
      end
      default: begin
        if (qtick) begin
          n_phase = phase + 2'd1;
          if (state == ACKS && phase == 2'd2 && sda_s)
            n_ack = 1'b1;
          if (phase == 2'd3) begin
            case (state)
              START: begin
                n_state = BIT;
                n_byte  = 2'd0;
                n_bit   = 3'd7;
              end
              BIT: begin
                n_shift = {shreg[22:0], 1'b0};
                if (bit_idx == 3'd0)
                  n_state = ACKS;
                else
                  n_bit = bit_idx - 3'd1;
              end
              ACKS: begin
                if (byte_idx == 2'd2 || (ABORT && ack_r)) begin
                  n_state = STOP;
                end else begin
                  n_state = BIT;
                  n_byte  = byte_idx + 2'd1;
                  n_bit   = 3'd7;
                end
              end
              STOP: begin
                n_state = DONE;
                n_end   = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  // Bus levels are decoded from the next state/phase and then registered,
  // so every pin change lines up with a single clock edge.
  always_comb begin
    n_scl = 1'b1;
    n_oe  = 1'b0;
    case (n_state)
      START: begin
        n_scl = (n_phase < 2'd2);
        n_oe  = (n_phase != 2'd0);
      end
      BIT: begin
        n_scl = (n_phase == 2'd1) || (n_phase == 2'd2);
        n_oe  = ~n_shift[23];
      end
      ACKS: begin
        n_scl = (n_phase == 2'd1) || (n_phase == 2'd2);
        n_oe  = 1'b0;
      end
      STOP: begin
        n_scl = (n_phase != 2'd0);
        n_oe  = (n_phase < 2'd2);
      end
      default: begin
        n_scl = 1'b1;
        n_oe  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= 2'd0;
      cnt      <= '0;
      shreg    <= '0;
      byte_idx <= 2'd0;
      bit_idx  <= 3'd0;
      end_r    <= 1'b0;
      ack_r    <= 1'b0;
      scl      <= 1'b1;
      sda_oe   <= 1'b0;
      sda_m    <= 1'b1;
      sda_s    <= 1'b1;
    end else begin
      state    <= n_state;
      phase    <= n_phase;
      shreg    <= n_shift;
      byte_idx <= n_byte;
      bit_idx  <= n_bit;
      end_r    <= n_end;
      ack_r    <= n_ack;
      scl      <= n_scl;
      sda_oe   <= n_oe;
      sda_m    <= FPGA_I2C_SDAT;
      sda_s    <= sda_m;
      if (state == IDLE || qtick)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

endmodule
